// File: rtl/ws2812b_frame_reader.sv
// Streams one WS2812B frame (3*NUM_LEDS bytes) from SRAM into a 2-entry FIFO feeding the serializer.
// Optional WS2812B_FRAME_READER_AUTORESTART_EN adds a latch gap and automatic frame restart.
module ws2812b_frame_reader #(
  parameter int unsigned NUM_LEDS     = 64,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned LATCH_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic [16:0] r_address,
  output logic        r_request,
  input  logic        r_started,
  input  logic        r_done,
  input  logic [7:0]  r_data,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        frame_done
);

  localparam int unsigned NumBytes = 3 * NUM_LEDS;
  localparam logic [16:0] LastIdx  = 17'(NumBytes - 1);
  localparam logic [16:0] BaseAddr = 17'(BASE_ADDR);

`ifdef WS2812B_FRAME_READER_AUTORESTART_EN
  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StGap} state_e;
  logic [31:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;
  logic unused_latch_cycles;
  assign unused_latch_cycles = ^32'(LATCH_CYCLES);
`endif

  state_e      state_q, state_d;
  logic [16:0] idx_q, idx_d;
  logic [7:0]  fifo_data_q [2];
  logic [1:0]  fifo_last_q;
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;
  logic        push, pop;

  // Only a read completing in StWait is real; late or stray r_done pulses are dropped.
  assign push      = (state_q == StWait) && r_done;
  assign pix_valid = (count_q != 2'd0);
  assign pop       = pix_valid && pix_ready;
  assign pix_data  = fifo_data_q[rd_ptr_q];
  assign pix_last  = fifo_last_q[rd_ptr_q] && pix_valid;
  assign busy      = (state_q == StReq) || (state_q == StWait) || (state_q == StDrain);
  assign r_address = r_request ? (BaseAddr + idx_q) : 17'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_data_q[0] <= 8'd0;
      fifo_data_q[1] <= 8'd0;
      fifo_last_q    <= 2'b00;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= r_data;
        fifo_last_q[wr_ptr_q] <= (idx_q == LastIdx);
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 17'd0;
`ifdef WS2812B_FRAME_READER_AUTORESTART_EN
      gap_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef WS2812B_FRAME_READER_AUTORESTART_EN
      gap_q   <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    r_request  = 1'b0;
    frame_done = 1'b0;
`ifdef WS2812B_FRAME_READER_AUTORESTART_EN
    gap_d      = gap_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = 17'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        // No read is outstanding here, so one free slot is enough to issue.
        if (count_q != 2'd2) begin
          r_request = 1'b1;
          if (r_started) state_d = StWait;
        end
      end
      StWait: begin
        if (r_done) begin
          idx_d   = idx_q + 17'd1;
          state_d = (idx_q == LastIdx) ? StDrain : StReq;
        end
      end
      StDrain: begin
        if (count_q == 2'd0) begin
          frame_done = 1'b1;
`ifdef WS2812B_FRAME_READER_AUTORESTART_EN
          gap_d      = 32'd0;
          state_d    = StGap;
`else
          state_d    = StIdle;
`endif
        end
      end
`ifdef WS2812B_FRAME_READER_AUTORESTART_EN
      StGap: begin
        if (gap_q == 32'(LATCH_CYCLES - 1)) begin
          idx_d   = 17'd0;
          state_d = StReq;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/ws2812b_frame_reader.md
WS2812B_FRAME_READER -- requirements
Module: ws2812b_frame_reader

Interface
REQ-001 Parameter NUM_LEDS, default 64; LEDs per frame; bytes per frame B = 3*NUM_LEDS; legal range 1..43690.
REQ-002 Parameter BASE_ADDR, default 0; 17-bit byte address of the first frame byte.
REQ-003 Parameter LATCH_CYCLES, default 5000; idle gap in clk cycles between frames; used only with the configuration macro.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins a frame read.
REQ-007 busy  output  1  high from frame start until frame_done.
REQ-008 r_address  output  17  byte address presented to the SRAM read port.
REQ-009 r_request  output  1  read request to the SRAM controller.
REQ-010 r_started  input  1  controller has accepted the read.
REQ-011 r_done  input  1  one-cycle pulse; r_data is valid.
REQ-012 r_data  input  8  byte returned by the controller.
REQ-013 pix_data  output  8  byte to the LED serializer.
REQ-014 pix_valid  output  1  pix_data is valid.
REQ-015 pix_ready  input  1  serializer accepts the byte when high together with pix_valid.
REQ-016 pix_last  output  1  high with pix_valid on the frame's final byte.
REQ-017 frame_done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DRAIN and GAP; GAP exists only with the macro.
REQ-019 IDLE: start=1 SHALL clear the byte index i and move to REQ; busy goes high the next cycle.
REQ-020 REQ: if FIFO occupancy is below 2, SHALL drive r_address = (BASE_ADDR+i) mod 2^17 and r_request=1, holding both until r_started=1.
REQ-021 On r_started=1 the block SHALL drop r_request the next cycle and enter WAIT.
REQ-022 WAIT: on r_done=1 the block SHALL push r_data into the FIFO and increment i. If i reaches B it enters DRAIN, else it returns to REQ.
REQ-023 The FIFO is 2 entries deep. At most one read is outstanding. A request is issued only when a free FIFO slot exists, counting the outstanding read.
REQ-024 Read latency: r_done SHALL push data that appears on pix_data no earlier than the next cycle.
REQ-025 Handshake: pix_data and pix_valid SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-026 A simultaneous FIFO push and pop SHALL keep occupancy unchanged and lose no data.
REQ-027 pix_last SHALL be 1 exactly when the popped entry has index B-1.
REQ-028 DRAIN: once the FIFO is empty after the last accept, the block SHALL pulse frame_done for one cycle, drop busy, and go to IDLE (or GAP with the macro).
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 r_done in IDLE, or in any state other than WAIT, SHALL be ignored.
REQ-031 Address arithmetic SHALL wrap modulo 2^17 with no error indication.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, i=0, empty FIFO, r_request=0, r_address=0, pix_valid=0, pix_data=0, pix_last=0, busy=0, frame_done=0, gap counter=0.
REQ-033 Reset mid-frame SHALL abandon any outstanding read; a late r_done after reset is ignored per REQ-030.
REQ-034 Deassertion needs no synchronizer inside the block; the top level releases reset synchronously to clk.

Configuration
REQ-035 Macro WS2812B_FRAME_READER_AUTORESTART_EN defined: after frame_done the block SHALL enter GAP, count LATCH_CYCLES cycles with busy=0, then restart the frame as if start were pulsed. start is ignored in GAP.
REQ-036 Macro undefined: the GAP state and counter SHALL not exist; frames begin only on start.

Verification
REQ-037 NUM_LEDS=1, BASE_ADDR=0x100, memory returns 0xA1,0xB2,0xC3, pix_ready=1 -> pix_data sequence A1,B2,C3; pix_last only on C3; one frame_done pulse; addresses 0x100..0x102.
REQ-038 BASE_ADDR=0x1FFFE, NUM_LEDS=1 -> r_address sequence 0x1FFFE,0x1FFFF,0x00000.
REQ-039 pix_ready=0 for 20 cycles mid-frame -> exactly 2 bytes buffered, no r_request while the FIFO is full, pix_data stable, no loss after release.
REQ-040 reset pulsed while in WAIT, then r_done=1 with 0x55 -> no pix_valid; state IDLE; busy=0.
REQ-041 start pulsed while busy -> frame byte count stays 3*NUM_LEDS; single frame_done.
REQ-042 With the macro and LATCH_CYCLES=10 -> the second frame's first r_request is asserted exactly 10 cycles plus the fixed FSM overhead after frame_done; no start is needed.
